// File: rtl/rlc_serial_pkg.sv
// rlc_serial_pkg
// Shared definitions for the RLC serial shift-register controller:
// register addresses, STATUS/CTRL bit positions and the FSM state type.
// Optional feature macro used by the controller: RLC_SERIAL_IRQ_EN.
package rlc_serial_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CLKDIV = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVERRUN = 2;

    localparam int CTRL_NBITS_W   = 6;
    localparam int CTRL_LSB_FIRST = 8;
    localparam int CTRL_IRQ_EN    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

endpackage

// File: rtl/rlc_serial_tick_gen.sv
// rlc_serial_tick_gen
// Half-period timer. Loads reload_val when reload is asserted, then counts
// down to zero and holds there. tick is high while the count is zero, so a
// reload of D gives exactly D+1 cycles from reload to the cycle with tick.
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   reload        - load reload_val on the next edge
//   reload_val    - half-period minus one
//   tick          - last cycle of the current half-period
module rlc_serial_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             reload,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= reload_val;
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/rlc_serial_shift_ctrl.sv
// rlc_serial_shift_ctrl
// Avalon-MM slave that shifts a software-written word out to the RLC game's
// external shift-register chain, then pulses the storage latch.
// Optional feature: define RLC_SERIAL_IRQ_EN to add the irq output and the
// CTRL.irq_en bit.
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    - Avalon-MM write side (write = chipselect && !write_n)
//   readdata              - combinational register read, zero wait states
//   ser_clk               - serial clock, idles low
//   ser_data              - serial data, changes only while ser_clk is low
//   ser_latch             - latch pulse after the last bit
//   irq                   - (RLC_SERIAL_IRQ_EN only) STATUS.done && CTRL.irq_en
module rlc_serial_shift_ctrl
    import rlc_serial_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ser_clk,
    output logic        ser_data,
    output logic        ser_latch
`ifdef RLC_SERIAL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [CTRL_NBITS_W-1:0] NB_MAX = CTRL_NBITS_W'(DATA_W - 1);

    state_t state, state_nxt;

    logic                    wr_en, wr_data, wr_status, wr_clkdiv, wr_ctrl;
    logic                    busy, start, shift, finish, tick, reload;
    logic [DATA_W-1:0]       wd, wd_aligned, data_reg, shreg, shreg_nxt;
    logic [DIV_W-1:0]        clkdiv, div_snap, reload_val;
    logic [CTRL_NBITS_W-1:0] nbits_m1, nb_snap, nb_wr, bit_cnt;
    logic                    lsb_first, lsb_snap, done, overrun;
    logic                    irq_en;
    logic                    unused_wd;

    assign unused_wd = ^writedata;

    assign wr_en     = chipselect && !write_n;
    assign wr_data   = wr_en && (address == ADDR_DATA);
    assign wr_status = wr_en && (address == ADDR_STATUS);
    assign wr_clkdiv = wr_en && (address == ADDR_CLKDIV);
    assign wr_ctrl   = wr_en && (address == ADDR_CTRL);

    assign busy  = (state != IDLE);
    assign start = wr_data && !busy;

    assign wd    = writedata[DATA_W-1:0];
    // MSB-first words are pre-aligned so the first bit always sits at the top.
    assign wd_aligned = wd << (NB_MAX - nbits_m1);
    assign nb_wr = (writedata[CTRL_NBITS_W-1:0] > NB_MAX) ? NB_MAX
                                                          : writedata[CTRL_NBITS_W-1:0];

    assign shreg_nxt = lsb_snap ? (shreg >> 1) : (shreg << 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: if (tick)  state_nxt = HIGH;
            HIGH: begin
                if (tick) begin
                    if (bit_cnt == nb_snap) begin
                        state_nxt = LATCH;
                    end else begin
                        state_nxt = SETUP;
                        shift     = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Timer restarts on every state change; the very first half-period uses
    // the live CLKDIV because the snapshot is taken on that same edge.
    assign reload     = (state_nxt != state);
    assign reload_val = start ? clkdiv : div_snap;

    rlc_serial_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk        (clk),
        .reset_n    (reset_n),
        .reload     (reload),
        .reload_val (reload_val),
        .tick       (tick)
    );

    // Shift path and serial outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            div_snap  <= '0;
            nb_snap   <= '0;
            lsb_snap  <= 1'b0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
        end else begin
            ser_clk   <= (state_nxt == HIGH);
            ser_latch <= (state_nxt == LATCH);
            if (start) begin
                shreg    <= lsb_first ? wd : wd_aligned;
                ser_data <= lsb_first ? wd[0] : wd_aligned[DATA_W-1];
                bit_cnt  <= '0;
                div_snap <= clkdiv;
                nb_snap  <= nbits_m1;
                lsb_snap <= lsb_first;
            end else if (shift) begin
                shreg    <= shreg_nxt;
                ser_data <= lsb_snap ? shreg_nxt[0] : shreg_nxt[DATA_W-1];
                bit_cnt  <= bit_cnt + CTRL_NBITS_W'(1);
            end else if (finish) begin
                ser_data <= 1'b0;
            end
        end
    end

    // Software-visible registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= '0;
            clkdiv    <= DIV_W'(DEFAULT_DIV);
            nbits_m1  <= NB_MAX;
            lsb_first <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (start) data_reg <= wd;
            if (wr_clkdiv) clkdiv <= writedata[DIV_W-1:0];
            if (wr_ctrl) begin
                nbits_m1  <= nb_wr;
                lsb_first <= writedata[CTRL_LSB_FIRST];
            end
            // Completion wins over a simultaneous STATUS clear.
            if (finish) begin
                done <= 1'b1;
            end else if (wr_status) begin
                done <= 1'b0;
            end
            if (wr_data && busy) begin
                overrun <= 1'b1;
            end else if (wr_status) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef RLC_SERIAL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en <= writedata[CTRL_IRQ_EN];
        end
    end

    assign irq = done && irq_en;
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[DATA_W-1:0] = data_reg;
            ADDR_STATUS: begin
                readdata[ST_BUSY]    = busy;
                readdata[ST_DONE]    = done;
                readdata[ST_OVERRUN] = overrun;
            end
            ADDR_CLKDIV: readdata[DIV_W-1:0] = clkdiv;
            ADDR_CTRL: begin
                readdata[CTRL_NBITS_W-1:0] = nbits_m1;
                readdata[CTRL_LSB_FIRST]   = lsb_first;
                readdata[CTRL_IRQ_EN]      = irq_en;
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rlc_serial_shift_ctrl.sv
// tb_rlc_serial_shift_ctrl
// Directed bench for rlc_serial_shift_ctrl. A transfer-level model predicts
// ser_clk/ser_data/ser_latch from the elapsed cycle count since start and the
// half-period length, and predicts register reads from the register rules.
// Literal expectations pin bit order, busy length, latch width and STATUS.
// A second instance with DATA_W=16 covers CTRL saturation.
// Honours RLC_SERIAL_IRQ_EN when defined.
module tb_rlc_serial_shift_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata, rd16;
    logic        ser_clk, ser_data, ser_latch;
    logic        s_clk, s_data, s_latch;
`ifdef RLC_SERIAL_IRQ_EN
    logic        irq, irq_s;
`endif

    rlc_serial_shift_ctrl #(.DATA_W(32), .DIV_W(16), .DEFAULT_DIV(24)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .ser_clk(ser_clk), .ser_data(ser_data), .ser_latch(ser_latch)
`ifdef RLC_SERIAL_IRQ_EN
        , .irq(irq)
`endif
    );

    rlc_serial_shift_ctrl #(.DATA_W(16), .DIV_W(16), .DEFAULT_DIV(24)) u_small (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd16),
        .ser_clk(s_clk), .ser_data(s_data), .ser_latch(s_latch)
`ifdef RLC_SERIAL_IRQ_EN
        , .irq(irq_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // model state
    int          m_div, m_nb, m_k, m_D, m_N;
    bit          m_lsb, m_irqen, m_act, m_done, m_ovr, m_wl;
    logic [31:0] m_data, m_word;

    // waveform observations
    bit          prev_clk, prev_latch;
    int          rise_cnt, latch_pulses, latch_cyc;
    logic [31:0] cap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div = 24; m_nb = 31; m_lsb = 0; m_irqen = 0;
        m_act = 0; m_done = 0; m_ovr = 0; m_k = 0;
        m_data = '0;
    endtask

    // Applies the bus write (if any) seen at this rising edge and advances time.
    task automatic model_edge();
        bit we, was_busy;
        we = chipselect && !write_n;
        was_busy = m_act;
        if (we && address == 2'd1) begin m_done = 0; m_ovr = 0; end
        if (we && address == 2'd2) m_div = int'(writedata[15:0]);
        if (we && address == 2'd3) begin
            m_nb  = (writedata[5:0] > 6'd31) ? 31 : int'(writedata[5:0]);
            m_lsb = writedata[8];
`ifdef RLC_SERIAL_IRQ_EN
            m_irqen = writedata[9];
`endif
        end
        if (was_busy) begin
            m_k++;
            if (m_k == (2 * m_N + 1) * (m_D + 1)) begin
                m_act  = 0;
                m_done = 1;
            end
        end
        if (we && address == 2'd0) begin
            if (was_busy) m_ovr = 1;
            else begin
                m_data = writedata; m_word = writedata;
                m_act = 1; m_k = 0;
                m_D = m_div; m_N = m_nb + 1; m_wl = m_lsb;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_data;
            2'd1:    return {29'd0, m_ovr, m_done, m_act};
            2'd2:    return 32'(m_div);
            default: return 32'(m_nb) | (32'(m_lsb) << 8) | (32'(m_irqen) << 9);
        endcase
    endfunction

    task automatic compare_cycle();
        int per, p, bi;
        bit eclk, elat, edat;
        eclk = 0; elat = 0; edat = 0; bi = 0;
        if (m_act) begin
            per = m_D + 1;
            p   = m_k / per;
            if (p < 2 * m_N) begin
                eclk = (p % 2) == 1;
                bi   = p / 2;
            end else begin
                elat = 1;
                bi   = m_N - 1;
            end
            edat = m_wl ? m_word[bi] : m_word[m_N - 1 - bi];
        end
        check("ser_clk",   32'(ser_clk),   32'(eclk));
        check("ser_data",  32'(ser_data),  32'(edat));
        check("ser_latch", 32'(ser_latch), 32'(elat));
        check("readdata",  readdata,       exp_rd(address));
`ifdef RLC_SERIAL_IRQ_EN
        check("irq", 32'(irq), 32'(m_done && m_irqen));
`endif
        if (ser_clk && !prev_clk) begin
            rise_cnt++;
            cap = {cap[30:0], ser_data};
        end
        if (ser_latch && !prev_latch) latch_pulses++;
        if (ser_latch) latch_cyc++;
        prev_clk   = ser_clk;
        prev_latch = ser_latch;
    endtask

    // One clock: model update at the rising edge, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        if (!reset_n) model_reset();
        compare_cycle();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        #1;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cycle();
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
        cycle();
        #1 address = a;
        #1 v = readdata;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        #1 address = 2'd1;
        for (int i = 0; i < 4000; i++) begin
            #1;
            if (!readdata[0]) return;
            n++;
            cycle();
        end
        check("idle_timeout", 32'(readdata[0]), 32'd0);
    endtask

    task automatic xfer(input logic [31:0] d, output int n);
        bus_wr(2'd0, d);
        wait_idle(n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r0, lp0, lc0;
        logic [31:0] v;

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;
        prev_clk = 0; prev_latch = 0; rise_cnt = 0; latch_pulses = 0;
        latch_cyc = 0; cap = '0;
        model_reset();
        cycle(); cycle();
        #1 reset_n = 1'b1;
        cycle();

        // reset state
        check("rst_ser_clk",   32'(ser_clk),   32'd0);
        check("rst_ser_data",  32'(ser_data),  32'd0);
        check("rst_ser_latch", 32'(ser_latch), 32'd0);
        check("rst_small_out", 32'({s_clk, s_data, s_latch}), 32'd0);
        bus_rd(2'd1, v); check("rst_status", v, 32'h0);
        bus_rd(2'd2, v); check("rst_clkdiv", v, 32'd24);
        bus_rd(2'd3, v); check("rst_ctrl",   v, 32'h1F);

        // MSB-first, DIV=1, 8 bits
        bus_wr(2'd2, 32'd1);
        bus_wr(2'd3, 32'h07);
        r0 = rise_cnt; lp0 = latch_pulses; lc0 = latch_cyc;
        xfer(32'hA5, n);
        check("msb_busy_cycles", 32'(n), 32'd34);
        check("msb_rises",       32'(rise_cnt - r0), 32'd8);
        check("msb_bits",        {24'd0, cap[7:0]}, 32'hA5);
        check("msb_latch_pulses", 32'(latch_pulses - lp0), 32'd1);
        check("msb_latch_width", 32'(latch_cyc - lc0), 32'd2);
        bus_rd(2'd1, v); check("msb_status_done", v, 32'h2);

        // LSB-first
        bus_wr(2'd1, 32'h0);
        bus_wr(2'd3, 32'h107);
        r0 = rise_cnt;
        xfer(32'hA5, n);
        check("lsb_a5_bits",  {24'd0, cap[7:0]}, 32'hA5);
        check("lsb_a5_rises", 32'(rise_cnt - r0), 32'd8);
        xfer(32'h01, n);
        check("lsb_01_bits",  {24'd0, cap[7:0]}, 32'h80);
        bus_rd(2'd3, v); check("lsb_ctrl_read", v, 32'h107);

        // overrun
        bus_wr(2'd1, 32'h0);
        bus_wr(2'd3, 32'h07);
        bus_wr(2'd0, 32'h0F);
        cycle(); cycle(); cycle();
        bus_wr(2'd0, 32'hF0);
        bus_rd(2'd1, v); check("ovr_status_busy", v, 32'h5);
        bus_rd(2'd0, v); check("ovr_data_kept",   v, 32'h0F);
        wait_idle(n);
        bus_rd(2'd1, v); check("ovr_status_after", v, 32'h6);
        check("ovr_bits", {24'd0, cap[7:0]}, 32'h0F);
        bus_wr(2'd1, 32'h0);
        bus_rd(2'd1, v); check("ovr_status_clear", v, 32'h0);

        // minimum transfer: DIV=0, one bit
        bus_wr(2'd2, 32'd0);
        bus_wr(2'd3, 32'h00);
        r0 = rise_cnt; lc0 = latch_cyc;
        xfer(32'h1, n);
        check("min_busy_cycles", 32'(n), 32'd3);
        check("min_rises",       32'(rise_cnt - r0), 32'd1);
        check("min_latch_width", 32'(latch_cyc - lc0), 32'd1);

        // CTRL saturation
        bus_wr(2'd3, 32'h3F);
        cycle();
        #1 address = 2'd3;
        #1;
        check("ctrl_sat_w16", rd16, 32'h0F);
        check("ctrl_sat_w32", readdata, 32'h1F);

        // reset in the middle of a transfer
        bus_wr(2'd1, 32'h0);
        bus_wr(2'd2, 32'd1);
        bus_wr(2'd3, 32'h07);
        r0 = rise_cnt; lp0 = latch_pulses;
        bus_wr(2'd0, 32'hA5);
        for (int i = 0; i < 200 && (rise_cnt - r0) < 3; i++) cycle();
        check("mid_three_rises", 32'(rise_cnt - r0), 32'd3);
        cycle();
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({ser_clk, ser_data, ser_latch}), 32'd0);
        cycle(); cycle();
        #1 reset_n = 1'b1;
        check("mid_no_latch", 32'(latch_pulses - lp0), 32'd0);
        bus_rd(2'd2, v); check("mid_clkdiv_reset", v, 32'd24);
        bus_wr(2'd2, 32'd1);
        bus_wr(2'd3, 32'h07);
        xfer(32'h3C, n);
        check("after_rst_busy", 32'(n), 32'd34);
        check("after_rst_bits", {24'd0, cap[7:0]}, 32'h3C);

`ifdef RLC_SERIAL_IRQ_EN
        bus_wr(2'd1, 32'h0);
        bus_wr(2'd3, 32'h207);
        xfer(32'h5A, n);
        check("irq_raised", 32'(irq), 32'd1);
        bus_wr(2'd1, 32'h0);
        #1;
        check("irq_cleared", 32'(irq), 32'd0);
        check("irq_small_idle", 32'(irq_s), 32'd0);
`endif

        cycle(); cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/rlc_serial_shift_ctrl.md
Name: rlc_serial_shift_ctrl

Overview:
- Avalon-MM slave that generates serial clock, data and latch waveforms in hardware for the RLC game's external shift-register chain.
- Replaces software bit-banging of the single-bit clock/data PIO outputs.
- Software writes a word; the block shifts it out at a programmable rate, pulses latch, and reports done.
- Sits on the Qsys system bus next to the existing PIOs; its outputs go to the same board pins.

Parameters:
- DATA_W, 32: maximum bits per transfer; width of the shift register (1..32).
- DIV_W, 16: width of the clock-divider register.
- DEFAULT_DIV, 24: reset value of CLKDIV; half-period = DEFAULT_DIV+1 clk cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; combinational, zero wait states, unused bits read 0
- ser_clk  out  1  serial clock to the shift-register chain; idles low
- ser_data  out  1  serial data; changes only while ser_clk is low
- ser_latch  out  1  storage-latch pulse after the last bit

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values: ser_clk=0, ser_data=0, ser_latch=0, state=IDLE, STATUS=0, CLKDIV=DEFAULT_DIV, CTRL.nbits_m1=DATA_W-1, CTRL.lsb_first=0, DATA=0.
- Register map. A write is chipselect && !write_n.
  - addr0 DATA: write latches writedata[DATA_W-1:0]. If IDLE, also starts a transfer. If busy, the write is ignored and STATUS.overrun is set. Reads return the last accepted data.
  - addr1 STATUS: bit0 busy, bit1 done (sticky), bit2 overrun (sticky). Any write clears bits 1 and 2.
  - addr2 CLKDIV: [DIV_W-1:0] = half-period minus 1.
  - addr3 CTRL: [5:0] nbits_m1, saturated to DATA_W-1 on write; bit8 lsb_first.
- Start: CLKDIV, nbits_m1 and lsb_first are snapshotted at transfer start. Writes to them during a transfer affect only the next transfer.
- FSM: IDLE -> SETUP -> HIGH -> (SETUP | LATCH) -> IDLE.
  - Start write at edge t: state=SETUP and busy=1 from t+1; ser_data = first bit (MSB of the nbits field, or bit0 if lsb_first) from t+1.
  - SETUP: ser_clk=0 for DIV+1 cycles, then -> HIGH.
  - HIGH: ser_clk=1 for DIV+1 cycles. At the end, if bit count == nbits_m1 -> LATCH; otherwise shift, present the next bit, -> SETUP.
  - LATCH: ser_clk=0, ser_latch=1 for DIV+1 cycles; then -> IDLE, busy=0, done=1, ser_latch=0, ser_data=0.
- Total busy time is (2N+1)(DIV+1) cycles, where N = nbits_m1+1.
- The divider counter reloads on every state entry. DIV=0 gives 1-cycle half-periods.
- If a STATUS-clear write and done being set land in the same cycle, set wins.
- If reset asserts mid-transfer, all outputs drop immediately. The external chain is left partially shifted and no latch pulse is issued.

Optional Feature:
- Macro RLC_SERIAL_IRQ_EN.
- Defined:
  - Adds output irq (1 bit). irq = STATUS.done && CTRL.irq_en (CTRL bit9, reset 0), level-sensitive, cleared by the STATUS write.
  - CTRL bit9 is readable and writable.
- Undefined: no irq port; CTRL bit9 reads 0 and ignores writes.

Decomposition:
- Package rlc_serial_pkg:
  - Register address constants ADDR_DATA/STATUS/CLKDIV/CTRL.
  - STATUS and CTRL bit-position constants.
  - FSM state enum (IDLE, SETUP, HIGH, LATCH).
- One sub-module, rlc_serial_tick_gen: DIV_W-bit down-counter with reload input and one-cycle tick output, used for all half-period timing.

Test Plan:
- Reset check: pulse reset_n low -> ser_* = 0; STATUS reads 0; CLKDIV reads 24; CTRL reads 0x1F (DATA_W=32).
- MSB-first: CLKDIV=1, CTRL=0x07, DATA=0xA5.
  - Bits sampled on ser_clk rising edges = 1,0,1,0,0,1,0,1.
  - One ser_latch pulse 2 cycles wide.
  - busy high for 34 cycles, then STATUS=0x2.
- LSB-first: CTRL=0x107, DATA=0xA5 -> sampled 1,0,1,0,0,1,0,1 reversed (1,0,1,0,0,1,0,1 read from bit0 up); also check DATA=0x01 gives 1,0,0,0,0,0,0,0.
- Overrun: DATA=0x0F, then DATA=0xF0 while busy.
  - Shifted word is 0x0F.
  - STATUS=0x5 during the transfer, 0x6 after it.
  - Writing STATUS afterwards gives 0x0.
- Boundaries:
  - CLKDIV=0, CTRL=0x00, DATA=0x1 -> exactly 1 rising edge, busy 3 cycles.
  - CTRL write of 0x3F with DATA_W=16 reads back 0x0F.
- Reset mid-transfer after 3 bits: reset_n low -> outputs 0 immediately, no latch; the next transfer runs normally.
- With RLC_SERIAL_IRQ_EN defined: CTRL bit9=1 -> irq rises in the cycle done sets; the STATUS write drops irq next cycle.
